// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between fetch, load/store, arbiter and memory.
// slave: arbiter view; master: requester/memory view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_address;
  logic              i_grant;
  logic              i_valid;
  logic [DATA_W-1:0] i_read_data;

  logic              d_req;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [DATA_W-1:0] d_write_data;
  logic              d_grant;
  logic              d_valid;
  logic [DATA_W-1:0] d_read_data;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;

  logic              busy;

  modport slave (
    input  i_req, i_address,
    input  d_req, d_write, d_address, d_write_data,
    input  mem_read_data,
    output i_grant, i_valid, i_read_data,
    output d_grant, d_valid, d_read_data,
    output mem_en, mem_we, mem_address, mem_write_data,
    output busy
  );

  modport master (
    output i_req, i_address,
    output d_req, d_write, d_address, d_write_data,
    output mem_read_data,
    input  i_grant, i_valid, i_read_data,
    input  d_grant, d_valid, d_read_data,
    input  mem_en, mem_we, mem_address, mem_write_data,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: fetch (read) and load/store share one port.
// Ports: clock, reset (async, high), bus (mem_port_arbiter_if.slave).
// Data side has priority; fetch wins after STARVE_LIMIT straight losses.
// MEM_PORT_ARBITER_STATS_EN adds i_grant_cnt, d_grant_cnt, conflict_cnt.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  mem_port_arbiter_if.slave     bus
`ifdef MEM_PORT_ARBITER_STATS_EN
  ,
  output logic [31:0]           i_grant_cnt,
  output logic [31:0]           d_grant_cnt,
  output logic [31:0]           conflict_cnt
`endif
);

  localparam int LW =
    (MEM_LATENCY < 1) ? 1 : $clog2(MEM_LATENCY + 1);
  localparam int SW =
    (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [LW-1:0] LAT = LW'(MEM_LATENCY);
  localparam logic [SW-1:0] STV = SW'(STARVE_LIMIT);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t            state_q, state_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              dsel_q, dsel_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_vld_q, i_vld_d;
  logic              d_vld_q, d_vld_d;
  logic              pick_i;
  logic              first;

  // Counter counts down from LAT, so LAT marks the strobe cycle.
  assign first = (state_q == ACCESS) && (lat_q == LAT);

  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    starve_d  = starve_q;
    dsel_d    = dsel_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_vld_d   = 1'b0;
    d_vld_d   = 1'b0;
    pick_i    = 1'b0;
    unique case (state_q)
      IDLE: begin
        pick_i = bus.i_req &&
                 (!bus.d_req || (starve_q == STV));
        if (bus.i_req || bus.d_req) begin
          state_d = ACCESS;
          lat_d   = LAT;
          dsel_d  = !pick_i;
          if (pick_i) begin
            addr_d   = bus.i_address;
            we_d     = 1'b0;
            starve_d = '0;
          end else begin
            addr_d  = bus.d_address;
            we_d    = bus.d_write;
            wdata_d = bus.d_write_data;
            if (bus.i_req && (starve_q != STV))
              starve_d = starve_q + 1'b1;
          end
        end
      end
      ACCESS: begin
        if (lat_q == '0) begin
          state_d = IDLE;
          if (dsel_q) begin
            d_vld_d = 1'b1;
            if (!we_q)
              d_rdata_d = bus.mem_read_data;
          end else begin
            i_vld_d   = 1'b1;
            i_rdata_d = bus.mem_read_data;
          end
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      lat_q     <= '0;
      starve_q  <= '0;
      dsel_q    <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_vld_q   <= 1'b0;
      d_vld_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      starve_q  <= starve_d;
      dsel_q    <= dsel_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_vld_q   <= i_vld_d;
      d_vld_q   <= d_vld_d;
    end
  end

`ifdef MEM_PORT_ARBITER_STATS_EN
  logic [31:0] icnt_q, dcnt_q, ccnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      icnt_q <= '0;
      dcnt_q <= '0;
      ccnt_q <= '0;
    end else begin
      if (first && !dsel_q)
        icnt_q <= icnt_q + 32'd1;
      if (first && dsel_q)
        dcnt_q <= dcnt_q + 32'd1;
      if ((state_q == IDLE) && bus.i_req && bus.d_req)
        ccnt_q <= ccnt_q + 32'd1;
    end
  end

  assign i_grant_cnt  = icnt_q;
  assign d_grant_cnt  = dcnt_q;
  assign conflict_cnt = ccnt_q;
`endif

  assign bus.i_grant        = first && !dsel_q;
  assign bus.d_grant        = first && dsel_q;
  assign bus.mem_en         = first;
  assign bus.mem_we         = first && we_q;
  assign bus.mem_address    = addr_q;
  assign bus.mem_write_data = wdata_q;
  assign bus.i_valid        = i_vld_q;
  assign bus.d_valid        = d_vld_q;
  assign bus.i_read_data    = i_rdata_q;
  assign bus.d_read_data    = d_rdata_q;
  assign bus.busy           = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: three instances at
// MEM_LATENCY 1 (main), 3 (reset abort) and 0 (streaming fetch).
module tb_mem_port_arbiter;
  localparam int LA = 1;
  localparam int LC = 3;
  localparam int LZ = 0;
  localparam int SL = 4;

  typedef struct packed {
    logic        st;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_c, rst_z;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ba();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bc();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bz();

`ifdef MEM_PORT_ARBITER_STATS_EN
  logic [31:0] ic, dc, cc;
  logic [31:0] ic_c, dc_c, cc_c;
  logic [31:0] ic_z, dc_z, cc_z;
`endif

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32),
    .MEM_LATENCY(LA), .STARVE_LIMIT(SL)
  ) u_a (
    .clock(clk), .reset(rst_a), .bus(ba)
`ifdef MEM_PORT_ARBITER_STATS_EN
    , .i_grant_cnt(ic), .d_grant_cnt(dc), .conflict_cnt(cc)
`endif
  );

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32),
    .MEM_LATENCY(LC), .STARVE_LIMIT(SL)
  ) u_c (
    .clock(clk), .reset(rst_c), .bus(bc)
`ifdef MEM_PORT_ARBITER_STATS_EN
    , .i_grant_cnt(ic_c), .d_grant_cnt(dc_c), .conflict_cnt(cc_c)
`endif
  );

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32),
    .MEM_LATENCY(LZ), .STARVE_LIMIT(SL)
  ) u_z (
    .clock(clk), .reset(rst_z), .bus(bz)
`ifdef MEM_PORT_ARBITER_STATS_EN
    , .i_grant_cnt(ic_z), .d_grant_cnt(dc_z), .conflict_cnt(cc_z)
`endif
  );

  // Memory: read is a function of the held address, writes from u_a only.
  logic [31:0] mem   [0:255];
  logic [31:0] m_mem [0:255];
  assign ba.mem_read_data = mem[ba.mem_address[9:2]];
  assign bc.mem_read_data = mem[bc.mem_address[9:2]];
  assign bz.mem_read_data = mem[bz.mem_address[9:2]];
  always @(posedge clk)
    if (ba.mem_en && ba.mem_we)
      mem[ba.mem_address[9:2]] <= ba.mem_write_data;

  int          n_chk = 0;
  int          n_fail = 0;
  exp_t        iq[$];
  exp_t        dq[$];
  logic [31:0] last_load = '0;
  int          we_cnt = 0;
  int          c_valids = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor for the main instance: pops expectations on valid pulses.
  initial begin : monitor
    int   losses;
    int   gi;
    int   gd;
    logic ireq_prev;
    exp_t e;
    losses = 0; gi = 0; gd = 0; ireq_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_a) begin
        losses    = 0;
        ireq_prev = 1'b0;
      end else begin
        if (ba.mem_we) we_cnt++;
        if (ba.i_grant) begin
          gi = cyc;
          losses = 0;
          chk("mem_we on fetch grant", {31'd0, ba.mem_we}, 32'd0);
        end
        if (ba.d_grant) begin
          gd = cyc;
          if (ireq_prev) begin
            losses++;
            chk("fetch starvation bound",
                {31'd0, losses <= SL}, 32'd1);
          end
        end
        if (ba.i_valid) begin
          if (iq.size() == 0) begin
            chk("unexpected i_valid", 32'd1, 32'd0);
          end else begin
            e = iq.pop_front();
            chk("i_read_data", ba.i_read_data, e.data);
            chk("fetch latency", 32'(cyc - gi), 32'(LA + 1));
          end
        end
        if (ba.d_valid) begin
          if (dq.size() == 0) begin
            chk("unexpected d_valid", 32'd1, 32'd0);
          end else begin
            e = dq.pop_front();
            if (e.st)
              chk("d_read_data kept on store", ba.d_read_data, e.data);
            else
              chk("load d_read_data", ba.d_read_data, e.data);
            chk("data latency", 32'(cyc - gd), 32'(LA + 1));
          end
        end
        ireq_prev = ba.i_req;
      end
    end
  end

  initial begin : mon_c
    forever begin
      @(negedge clk);
      if (bc.i_valid) c_valids++;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic fetch_a(input logic [31:0] a);
    int n;
    exp_t e;
    n = 0;
    ba.i_req = 1'b1;
    ba.i_address = a;
    do begin
      @(posedge clk); #1; n++;
    end while (!ba.i_grant && n < 100);
    if (!ba.i_grant) begin
      chk("i_grant timeout", 32'd0, 32'd1);
    end else begin
      e.st = 1'b0;
      e.data = m_mem[a[9:2]];
      iq.push_back(e);
    end
    ba.i_req = 1'b0;
  endtask

  task automatic data_a(input logic w, input logic [31:0] a,
                        input logic [31:0] wd);
    int n;
    exp_t e;
    n = 0;
    ba.d_req = 1'b1;
    ba.d_write = w;
    ba.d_address = a;
    ba.d_write_data = wd;
    do begin
      @(posedge clk); #1; n++;
    end while (!ba.d_grant && n < 100);
    if (!ba.d_grant) begin
      chk("d_grant timeout", 32'd0, 32'd1);
    end else begin
      if (w) m_mem[a[9:2]] = wd;
      else   last_load = m_mem[a[9:2]];
      e.st = w;
      e.data = last_load;
      dq.push_back(e);
    end
    ba.d_req = 1'b0;
    ba.d_write = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((iq.size() != 0 || dq.size() != 0) && n < 50) begin
      @(negedge clk); n++;
    end
    chk("scoreboard drained", 32'(iq.size() + dq.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic chk_zero_a(input string tag);
    chk({tag, " ctrl"}, {25'd0, ba.busy, ba.i_grant, ba.d_grant,
        ba.i_valid, ba.d_valid, ba.mem_en, ba.mem_we}, 32'd0);
    chk({tag, " mem_address"}, ba.mem_address, 32'd0);
    chk({tag, " mem_write_data"}, ba.mem_write_data, 32'd0);
    chk({tag, " i_read_data"}, ba.i_read_data, 32'd0);
    chk({tag, " d_read_data"}, ba.d_read_data, 32'd0);
  endtask

  task automatic reset_a();
    @(posedge clk); #1;
    rst_a = 1'b1;
    #1;
    chk_zero_a("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    last_load = '0;
    @(posedge clk); #1;
  endtask

  initial begin : stim
    logic [31:0] v;
    logic [31:0] fa;
    logic [31:0] da;
    logic        seq[$];
    int          vc[$];
    logic [31:0] vd[$];
    int          ng;
    int          n;
    int          we0;

    rst_a = 1'b1; rst_c = 1'b1; rst_z = 1'b1;
    ba.i_req = 0; ba.i_address = '0; ba.d_req = 0; ba.d_write = 0;
    ba.d_address = '0; ba.d_write_data = '0;
    bc.i_req = 0; bc.i_address = '0; bc.d_req = 0; bc.d_write = 0;
    bc.d_address = '0; bc.d_write_data = '0;
    bz.i_req = 0; bz.i_address = '0; bz.d_req = 0; bz.d_write = 0;
    bz.d_address = '0; bz.d_write_data = '0;
    for (int i = 0; i < 256; i++) begin
      v = (i == 0) ? 32'h0050_0093 : $urandom;
      m_mem[i] = v;
      mem[i] <= v;
    end

    // Reset state, then first fetch after release.
    repeat (3) @(posedge clk);
    #1;
    chk_zero_a("initial reset");
    ba.i_req = 1'b1;
    ba.i_address = 32'h0;
    @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    chk("cycle1 grant/busy/en/we",
        {28'd0, ba.i_grant, ba.busy, ba.mem_en, ba.mem_we}, 32'hE);
    iq.push_back('{st: 1'b0, data: 32'h0050_0093});
    @(posedge clk); #1;
    ba.i_req = 1'b0;
    @(negedge clk);
    chk("cycle2 grant/busy/valid",
        {29'd0, ba.i_grant, ba.busy, ba.i_valid}, 32'h2);
    @(negedge clk);
    chk("cycle3 busy/valid", {30'd0, ba.busy, ba.i_valid}, 32'h1);
    @(posedge clk); #1;

    // Store then load of the same word.
    we0 = we_cnt;
    data_a(1'b1, 32'h100, 32'hDEAD_BEEF);
    wait_drain();
    chk("store mem_we cycles", 32'(we_cnt - we0), 32'd1);
    data_a(1'b0, 32'h100, 32'h0);
    wait_drain();
    chk("load after store", ba.d_read_data, 32'hDEAD_BEEF);

    // Contention from a clean reset: both requests held for 10 grants.
    reset_a();
    fa = 32'h0;
    da = 32'h200;
    ng = 0;
    n = 0;
    ba.i_req = 1'b1; ba.i_address = fa;
    ba.d_req = 1'b1; ba.d_write = 1'b0; ba.d_address = da;
    while (ng < 10 && n < 200) begin
      @(posedge clk); #1; n++;
      if (ba.i_grant) begin
        seq.push_back(1'b1);
        iq.push_back('{st: 1'b0, data: m_mem[fa[9:2]]});
        fa = fa + 32'd4;
        ba.i_address = fa;
        ng++;
      end
      if (ba.d_grant) begin
        seq.push_back(1'b0);
        last_load = m_mem[da[9:2]];
        dq.push_back('{st: 1'b0, data: last_load});
        da = da + 32'd4;
        ba.d_address = da;
        ng++;
      end
    end
    ba.i_req = 1'b0;
    ba.d_req = 1'b0;
    chk("contention grant count", 32'(ng), 32'd10);
    for (int k = 0; k < seq.size(); k++)
      chk($sformatf("grant order %0d (1=fetch)", k),
          {31'd0, seq[k]}, {31'd0, (k % 5) == 4});
    wait_drain();
`ifdef MEM_PORT_ARBITER_STATS_EN
    chk("i_grant_cnt", ic, 32'd2);
    chk("d_grant_cnt", dc, 32'd8);
    chk("conflict_cnt", cc, 32'd10);
`endif

    // Randomized concurrent traffic.
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
          end
          fetch_a(32'(4 * $urandom_range(0, 63)));
        end
      end
      begin
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
          end
          data_a(1'($urandom_range(0, 1)),
                 32'(32'h200 + 4 * $urandom_range(0, 127)),
                 $urandom);
        end
      end
    join
    wait_drain();

    // MEM_LATENCY=3: reset in the middle of an access.
    bc.i_req = 1'b1;
    bc.i_address = 32'h4;
    @(negedge clk);
    rst_c = 1'b0;
    @(negedge clk);
    chk("lat3 grant", {31'd0, bc.i_grant}, 32'd1);
    @(posedge clk); #1;
    rst_c = 1'b1;
    #1;
    chk("lat3 abort ctrl", {27'd0, bc.busy, bc.i_grant, bc.i_valid,
        bc.mem_en, bc.mem_we}, 32'd0);
    chk("lat3 abort mem_address", bc.mem_address, 32'd0);
    chk("lat3 abort i_read_data", bc.i_read_data, 32'd0);
    repeat (5) @(negedge clk);
    chk("lat3 no valid in reset", 32'(c_valids), 32'd0);
    rst_c = 1'b0;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!bc.i_grant && n < 20);
    chk("lat3 regrant cycle", 32'(n), 32'd1);
    @(posedge clk); #1;
    bc.i_req = 1'b0;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!bc.i_valid && n < 20);
    chk("lat3 valid delay", 32'(n), 32'(LC + 1));
    chk("lat3 i_read_data", bc.i_read_data, m_mem[1]);
    repeat (4) @(negedge clk);
    chk("lat3 valid count", 32'(c_valids), 32'd1);

    // MEM_LATENCY=0: streaming fetch with held request.
    bz.i_req = 1'b1;
    bz.i_address = 32'h0;
    @(negedge clk);
    rst_z = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      if (bz.i_grant) bz.i_address = bz.i_address + 32'd4;
      @(negedge clk);
      if (bz.i_valid) begin
        vc.push_back(cyc);
        vd.push_back(bz.i_read_data);
      end
    end
    bz.i_req = 1'b0;
    chk("lat0 valid count >= 3", {31'd0, vc.size() >= 3}, 32'd1);
    for (int k = 0; k < 3; k++)
      if (k < vc.size())
        chk($sformatf("lat0 data word %0d", k), vd[k], m_mem[k]);
    for (int k = 1; k < 3; k++)
      if (k < vc.size())
        chk($sformatf("lat0 period %0d", k),
            32'(vc[k] - vc[k-1]), 32'd2);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported main memory between the fetch unit (instruction side, read-only) and the load/store path (data side, read/write).
- Sits between fetch/decode and the memory model, replacing the dual i_/d_ ports with one arbitrated port.
- Sequences each access through a small FSM with a per-side request/grant/valid handshake.
- Applies fixed data-over-instruction priority, with an anti-starvation override for fetch.

Parameters:
ADDR_W, 32, width of all address buses
DATA_W, 32, width of all data buses
MEM_LATENCY, 1, cycles from the mem_en cycle until mem_read_data is valid (0 = combinational memory)
STARVE_LIMIT, 4, consecutive fetch losses that force the next arbitration to the instruction side

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
i_req  in  1  fetch request; held with i_address until i_grant
i_address  in  ADDR_W  fetch address
i_grant  out  1  one-cycle pulse: fetch request accepted
i_valid  out  1  one-cycle pulse: i_read_data valid
i_read_data  out  DATA_W  fetched word, held until the next fetch completes
d_req  in  1  data request; held with d_write, d_address and d_write_data until d_grant
d_write  in  1  1 = store, 0 = load
d_address  in  ADDR_W  data address
d_write_data  in  DATA_W  store data
d_grant  out  1  one-cycle pulse: data request accepted
d_valid  out  1  one-cycle pulse: load data valid or store done
d_read_data  out  DATA_W  load word, held until the next load completes
mem_en  out  1  memory access strobe, one cycle per access
mem_we  out  1  memory write enable, qualified by mem_en
mem_address  out  ADDR_W  memory address
mem_write_data  out  DATA_W  memory write data
mem_read_data  in  DATA_W  memory read data
busy  out  1  high while the FSM is not IDLE

Behaviour:
- Reset, asynchronous:
  - FSM goes to IDLE, starve counter to 0, latency counter to 0.
  - All outputs go to 0, including both read-data registers.
  - An access in flight is aborted with no valid pulse.
- FSM states:
  - IDLE: arbitrate at each rising edge.
    - Neither request high: stay IDLE.
    - Otherwise: latch the winner, its address, write flag and write data; go to ACCESS; load the latency counter with MEM_LATENCY.
  - ACCESS:
    - First cycle: mem_en=1, mem_we = latched write flag; winner's grant=1.
    - mem_address and mem_write_data are held for the whole state.
    - Counter decrements each cycle. At an edge where the counter is 0:
      - Load: sample mem_read_data into the winner's read-data register.
      - Both: set the winner's valid for the next cycle, return to IDLE.
- Timing, relative to accept edge E0:
  - grant and mem_en high in cycle 1.
  - mem_read_data sampled at the end of cycle 1+MEM_LATENCY.
  - valid high in cycle 2+MEM_LATENCY, during which the FSM is already IDLE.
  - Back-to-back period is MEM_LATENCY+2 cycles.
- Arbitration:
  - d_req alone: data wins. i_req alone: fetch wins.
  - Both high: data wins, unless starve counter == STARVE_LIMIT, then fetch wins.
- Starve counter:
  - +1 when i_req is high and data wins; saturates at STARVE_LIMIT.
  - Cleared to 0 when fetch wins.
- Requests arriving while not in IDLE are not accepted. The requester holds them; they are evaluated at the first IDLE edge.
- Deassertion of a request after grant has no effect; the access completes and valid still pulses.
- Stores:
  - d_valid pulses; d_read_data is unchanged.
  - mem_we is never 1 for an instruction access.
- mem_address and mem_write_data keep their last values when idle. mem_en=0 whenever the FSM is not in the first ACCESS cycle.

Optional Feature:
- Macro MEM_PORT_ARBITER_STATS_EN.
- Defined: adds three output ports, all cleared by reset and wrapping at 2^32:
  - i_grant_cnt (32): number of fetch grants.
  - d_grant_cnt (32): number of data grants.
  - conflict_cnt (32): IDLE edges at which i_req and d_req were both high.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset released, i_req=1, i_address=0x00000000, memory word 0 = 0x00500093, MEM_LATENCY=1 -> i_grant in cycle 1, i_valid in cycle 3 with i_read_data=0x00500093, busy high cycles 1-2.
- d_req=1, d_write=1, d_address=0x00000100, d_write_data=0xDEADBEEF, then a load from 0x100 -> mem_we=1 for exactly one cycle; load returns d_read_data=0xDEADBEEF; d_read_data is unchanged after the store.
- i_req and d_req both held high continuously with STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I...; fetch is never starved beyond 4 losses.
- Reset asserted in the middle of ACCESS (cycle 2, MEM_LATENCY=3) -> outputs zero immediately, no valid pulse; after release, the held request is re-granted from IDLE.
- MEM_LATENCY=0, i_req held high -> i_valid every 2nd cycle with incrementing addresses 0x0, 0x4, 0x8 and correct data.
- With MEM_PORT_ARBITER_STATS_EN defined, run the contention scenario for 10 grants -> d_grant_cnt=8, i_grant_cnt=2, conflict_cnt=10.
